// File: rtl/gray_rgb_pkg.sv
// Shared types for the gray-to-RGB444 display expander.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package gray_rgb_pkg;

  localparam int GRAY_W = 8;
  localparam int RGB_W  = 12;
  localparam int CH_W   = 4;

  typedef enum logic [1:0] {
    MODE_REPL   = 2'd0,
    MODE_PSEUDO = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Stage-1 payload: the pixel plus the config that applies to it.
  typedef struct packed {
    logic [GRAY_W-1:0] gray;
    logic              sof;
    mode_e             mode;
    logic [GRAY_W-1:0] thresh;
  } s1_dat_t;

  // The reserved encoding falls back to plain replication.
  function automatic mode_e sanitize_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_REPL : mode_e'(m);
  endfunction

endpackage

// File: rtl/gray_colour_map.sv
// Maps one 8-bit gray pixel to RGB444 by replicate, heat-map or threshold.
// Latency: purely combinational.
// Backpressure: none; the caller owns the handshake.
module gray_colour_map
  import gray_rgb_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  input  mode_e             mode,
  input  logic [GRAY_W-1:0] thresh,
  output logic [RGB_W-1:0]  rgb12
);

  logic [1:0]      seg;
  logic [CH_W-1:0] f;
  logic [CH_W-1:0] r;
  logic [CH_W-1:0] g;
  logic [CH_W-1:0] b;

  assign seg = gray[7:6];
  assign f   = gray[5:2];

  // Select channel values for the active mode; the heat map walks
  // blue -> cyan -> green -> yellow -> red across the four segments.
  always_comb begin
    r = gray[7:4];
    g = gray[7:4];
    b = gray[7:4];
    case (mode)
      MODE_PSEUDO: begin
        case (seg)
          2'd0:    begin r = 4'd0;      g = f;         b = 4'd15;     end
          2'd1:    begin r = 4'd0;      g = 4'd15;     b = 4'd15 - f; end
          2'd2:    begin r = f;         g = 4'd15;     b = 4'd0;      end
          default: begin r = 4'd15;     g = 4'd15 - f; b = 4'd0;      end
        endcase
      end
      MODE_THRESH: begin
        if (gray >= thresh) begin
          r = 4'hF; g = 4'hF; b = 4'hF;
        end else begin
          r = 4'h0; g = 4'h0; b = 4'h0;
        end
      end
      default: begin
        r = gray[7:4];
        g = gray[7:4];
        b = gray[7:4];
      end
    endcase
  end

  assign rgb12 = {r, g, b};

endmodule

// File: rtl/gray_to_rgb444.sv
// Streaming gray -> RGB444 expander with per-frame mode/threshold latched at SOF.
// Latency: 2 cycles (stage 1 = pixel+config, stage 2 = mapped RGB), 1 pixel/clk.
// Backpressure: valid/ready; out_ready stalls both stages, in_ready drops when full.
module gray_to_rgb444
  import gray_rgb_pkg::*;
#(
  parameter logic [7:0] DEFAULT_THRESH = 8'd128,
  parameter int         FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode_cfg,
  input  logic [GRAY_W-1:0]      thresh_cfg,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [GRAY_W-1:0]      in_gray,
  input  logic                   in_sof,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RGB_W-1:0]       out_rgb,
  output logic                   out_sof,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic              advance;
  logic              in_fire;
  mode_e             cfg_mode;
  logic [GRAY_W-1:0] cfg_thresh;
  mode_e             eff_mode;
  logic [GRAY_W-1:0] eff_thresh;
  logic              s1_valid;
  s1_dat_t           s1_dat;
  logic [RGB_W-1:0]  map_rgb;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign in_fire  = in_valid && in_ready;

  // An SOF beat uses the freshly requested config; every other beat
  // reuses whatever was latched at the last accepted SOF.
  always_comb begin
    eff_mode   = cfg_mode;
    eff_thresh = cfg_thresh;
    if (in_sof) begin
      eff_mode   = sanitize_mode(mode_cfg);
      eff_thresh = thresh_cfg;
    end
  end

  // Hold the per-frame config, refreshed only by an accepted SOF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode   <= MODE_REPL;
      cfg_thresh <= DEFAULT_THRESH;
    end else if (in_fire && in_sof) begin
      cfg_mode   <= eff_mode;
      cfg_thresh <= eff_thresh;
    end
  end

  // Count accepted SOF beats; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (in_fire && in_sof) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Stage 1: capture the pixel with the config it must be rendered with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dat   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dat.gray   <= in_gray;
        s1_dat.sof    <= in_sof;
        s1_dat.mode   <= eff_mode;
        s1_dat.thresh <= eff_thresh;
      end
    end
  end

  gray_colour_map u_map (
    .gray   (s1_dat.gray),
    .mode   (s1_dat.mode),
    .thresh (s1_dat.thresh),
    .rgb12  (map_rgb)
  );

  // Stage 2: register the mapped pixel; held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_sof   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rgb <= map_rgb;
        out_sof <= s1_dat.sof;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_rgb444.sv
module tb_gray_to_rgb444;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_cfg;
  logic [7:0]  thresh_cfg;
  logic        in_valid;
  logic [7:0]  in_gray;
  logic        in_sof;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_rgb;
  logic        out_sof;
  logic [15:0] frame_cnt;

  logic        in_ready_w;
  logic        out_valid_w;
  logic [11:0] out_rgb_w;
  logic        out_sof_w;
  logic [1:0]  frame_cnt_w;

  always #5 clk = ~clk;

  gray_to_rgb444 #(.DEFAULT_THRESH(8'd128), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode_cfg(mode_cfg), .thresh_cfg(thresh_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
    .out_sof(out_sof), .frame_cnt(frame_cnt)
  );

  gray_to_rgb444 #(.DEFAULT_THRESH(8'd128), .FRAME_CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .mode_cfg(mode_cfg), .thresh_cfg(thresh_cfg),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_gray(in_gray), .in_sof(in_sof),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_rgb(out_rgb_w),
    .out_sof(out_sof_w), .frame_cnt(frame_cnt_w)
  );

  typedef struct {
    logic        sof;
    logic [1:0]  mode;
    logic [7:0]  thresh;
    logic [7:0]  gray;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t beats[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sof_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(output vec_t v, input logic sof, input logic [1:0] mode,
                     input logic [7:0] th, input logic [7:0] g, input logic [11:0] e);
    v.sof = sof; v.mode = mode; v.thresh = th; v.gray = g; v.exp_rgb = e;
  endtask

  task automatic push(input logic sof, input logic [1:0] mode, input logic [7:0] th,
                      input logic [7:0] g, input logic [11:0] e);
    vec_t v;
    add(v, sof, mode, th, g, e);
    beats.push_back(v);
  endtask

  task automatic push_tbl(input logic sof, input logic [1:0] mode, input logic [7:0] th,
                          input logic [7:0] g, input logic [11:0] e);
    vec_t v;
    add(v, sof, mode, th, g, e);
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_gray  = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sof_model = 0;
  endtask

  // Drive the queued beats through both DUTs, stalling out_ready on the
  // cycles set in stall_mask, and score everything that comes out.
  task automatic run(input string name, input logic [31:0] stall_mask, input int budget);
    int n, idx, got, cyc;
    logic prev_hold, prev_stall, prev_inv, stall, acc_in, acc_out, prev_sof;
    logic [11:0] prev_rgb;
    n = beats.size(); idx = 0; got = 0; cyc = 0;
    prev_hold = 0; prev_stall = 0; prev_inv = 0; prev_rgb = 0; prev_sof = 0;
    while ((idx < n || got < n) && cyc < budget) begin
      stall = (cyc < 32) ? stall_mask[cyc] : 1'b0;
      out_ready = !stall;
      if (idx < n) begin
        in_valid = 1'b1; in_sof = beats[idx].sof; mode_cfg = beats[idx].mode;
        thresh_cfg = beats[idx].thresh; in_gray = beats[idx].gray;
      end else begin
        idle_inputs();
      end
      #1;
      if (prev_hold) begin
        chk({name, " hold valid"}, 32'(out_valid), 32'd1);
        chk({name, " hold rgb"}, 32'(out_rgb), 32'(prev_rgb));
        chk({name, " hold sof"}, 32'(out_sof), 32'(prev_sof));
      end
      if (!stall) begin
        chk({name, " in_ready free"}, 32'(in_ready), 32'd1);
        chk({name, " in_ready free w"}, 32'(in_ready_w), 32'd1);
      end
      if (stall && prev_stall && prev_inv && out_valid)
        chk({name, " in_ready full"}, 32'(in_ready), 32'd0);
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (got < n) begin
          chk({name, " rgb"}, 32'(out_rgb), 32'(beats[got].exp_rgb));
          chk({name, " sof"}, 32'(out_sof), 32'(beats[got].sof));
          chk({name, " w valid"}, 32'(out_valid_w), 32'd1);
          chk({name, " w rgb"}, 32'(out_rgb_w), 32'(beats[got].exp_rgb));
          chk({name, " w sof"}, 32'(out_sof_w), 32'(beats[got].sof));
        end else begin
          chk({name, " beat count"}, got + 1, n);
        end
        got++;
      end
      prev_hold = out_valid && !out_ready; prev_rgb = out_rgb; prev_sof = out_sof;
      prev_stall = stall; prev_inv = in_valid;
      @(posedge clk);
      #1;
      if (acc_in) begin
        if (in_sof) sof_model++;
        idx++;
      end
      chk({name, " frame_cnt"}, 32'(frame_cnt), 32'(sof_model[15:0]));
      chk({name, " frame_cnt w"}, 32'(frame_cnt_w), 32'(sof_model[1:0]));
      cyc++;
    end
    chk({name, " beats delivered"}, got, n);
    idle_inputs();
    out_ready = 1'b1;
    beats.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({name, " drained"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {sof, mode, thresh, gray, expected rgb}
    push_tbl(1, 2'd1, 8'h80, 8'h50, 12'h0FB);
    push_tbl(0, 2'd1, 8'h80, 8'hC8, 12'hFD0);
    push_tbl(0, 2'd1, 8'h80, 8'h3F, 12'h0FF);
    push_tbl(0, 2'd1, 8'h80, 8'hFF, 12'hF00);
    push_tbl(1, 2'd2, 8'h80, 8'h7F, 12'h000);
    push_tbl(0, 2'd2, 8'h80, 8'h80, 12'hFFF);
    push_tbl(0, 2'd0, 8'h10, 8'h7F, 12'h000);
    push_tbl(1, 2'd3, 8'h10, 8'h7F, 12'h777);
    push_tbl(1, 2'd2, 8'h10, 8'h7F, 12'hFFF);
    push_tbl(0, 2'd2, 8'h10, 8'h0F, 12'h000);
    push_tbl(0, 2'd2, 8'h10, 8'h10, 12'hFFF);
    push_tbl(1, 2'd1, 8'h10, 8'h00, 12'h00F);
    push_tbl(0, 2'd1, 8'h10, 8'h40, 12'h0FF);
    push_tbl(0, 2'd1, 8'h10, 8'h80, 12'h0F0);
    push_tbl(0, 2'd1, 8'h10, 8'hBF, 12'hFF0);

    rst = 1'b1; mode_cfg = 2'd0; thresh_cfg = 8'h80; out_ready = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_rgb", 32'(out_rgb), 32'd0);
    chk("reset out_sof", 32'(out_sof), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Two-cycle latency, mode 0
    in_valid = 1; in_sof = 1; mode_cfg = 2'd0; thresh_cfg = 8'h80; in_gray = 8'hA7;
    #1;
    chk("lat in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    sof_model++;
    chk("lat cycle1 valid", 32'(out_valid), 32'd0);
    chk("lat frame_cnt", 32'(frame_cnt), 32'd1);
    in_sof = 0; in_gray = 8'h00;
    @(posedge clk); #1;
    idle_inputs();
    chk("lat cycle2 valid", 32'(out_valid), 32'd1);
    chk("lat A7 rgb", 32'(out_rgb), 32'h0AAA);
    chk("lat A7 sof", 32'(out_sof), 32'd1);
    @(posedge clk); #1;
    chk("lat 00 valid", 32'(out_valid), 32'd1);
    chk("lat 00 rgb", 32'(out_rgb), 32'h0000);
    chk("lat 00 sof", 32'(out_sof), 32'd0);
    @(posedge clk); #1;
    chk("lat empty", 32'(out_valid), 32'd0);

    // Table of mode vectors, free-flowing output
    beats = tbl;
    run("table", 32'h0, 200);

    // 16-pixel ramp with a 5-cycle output stall
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      push(i == 0, 2'd0, 8'h80, {k, 4'h5}, {k, k, k});
    end
    run("ramp", 32'h0000_00F8, 300);

    // SOF beats accepted under an output stall keep their own config
    push(1, 2'd1, 8'h80, 8'h50, 12'h0FB);
    push(1, 2'd2, 8'h80, 8'h80, 12'hFFF);
    push(0, 2'd0, 8'h10, 8'h7F, 12'h000);
    run("sofhold", 32'h0000_000F, 100);

    // Back-to-back SOFs and counter wrap on the 2-bit instance
    do_reset();
    push(1, 2'd1, 8'h80, 8'h50, 12'h0FB);
    push(1, 2'd2, 8'h80, 8'h80, 12'hFFF);
    push(1, 2'd0, 8'h80, 8'h50, 12'h555);
    push(1, 2'd2, 8'hFF, 8'hFE, 12'h000);
    push(0, 2'd1, 8'h00, 8'hFE, 12'h000);
    run("wrap", 32'h0, 100);
    chk("wrap frame_cnt 16b", 32'(frame_cnt), 32'd4);
    chk("wrap frame_cnt 2b", 32'(frame_cnt_w), 32'd0);

    // Reset with two pixels in flight
    in_valid = 1; in_sof = 1; mode_cfg = 2'd1; thresh_cfg = 8'h80; in_gray = 8'h50;
    @(posedge clk); #1;
    in_sof = 0; in_gray = 8'hC8;
    @(posedge clk); #1;
    idle_inputs();
    chk("inflight valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst drops valid", 32'(out_valid), 32'd0);
    chk("rst clears frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sof_model = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post-rst idle", 32'(out_valid), 32'd0);
    end
    in_valid = 1; in_sof = 0; mode_cfg = 2'd1; thresh_cfg = 8'h00; in_gray = 8'hC8;
    @(posedge clk); #1;
    idle_inputs();
    chk("post-rst lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("post-rst valid", 32'(out_valid), 32'd1);
    chk("post-rst rgb mode0", 32'(out_rgb), 32'h0CCC);
    chk("post-rst sof", 32'(out_sof), 32'd0);
    chk("post-rst frame_cnt", 32'(frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
